// File: rtl/program_loader_if.sv
// Byte-stream and memory-write bundle between a host byte source and the program loader.
interface program_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  modport master (
    output s_valid, s_data,
    input  s_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/program_loader.sv
// Program-image loader: streams bytes into memory with the core held, then
// releases the core once the trailing 8-bit additive checksum matches.
module program_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   load_len,
  program_loader_if.slave       bus,
  output logic                  cpu_run,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  localparam logic [ADDR_WIDTH:0] DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] IDX_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0] IDX_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  function automatic logic [DATA_WIDTH-1:0] csum_add(
    input logic [DATA_WIDTH-1:0] acc,
    input logic [DATA_WIDTH-1:0] b
  );
    return acc + b;
  endfunction

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   idx_q;
  logic [DATA_WIDTH-1:0] sum_q;
  logic                  s_ready_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  cpu_run_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  error_q;

  logic                  hs_s;
  logic [ADDR_WIDTH:0]   idx_d;
  logic [DATA_WIDTH-1:0] sum_d;
  logic [ADDR_WIDTH-1:0] wr_addr_d;

  // Handshake decode and next index/checksum/address; the address wraps at the memory size.
  always_comb begin
    hs_s      = bus.s_valid & s_ready_q;
    idx_d     = idx_q + IDX_ONE;
    sum_d     = csum_add(sum_q, bus.s_data);
    wr_addr_d = base_q + idx_q[ADDR_WIDTH-1:0];
  end

  // Loader FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      base_q      <= {ADDR_WIDTH{1'b0}};
      len_q       <= IDX_ZERO;
      idx_q       <= IDX_ZERO;
      sum_q       <= {DATA_WIDTH{1'b0}};
      s_ready_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_WIDTH{1'b0}};
      mem_wdata_q <= {DATA_WIDTH{1'b0}};
      cpu_run_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            base_q    <= base_addr;
            len_q     <= load_len;
            idx_q     <= IDX_ZERO;
            sum_q     <= {DATA_WIDTH{1'b0}};
            done_q    <= 1'b0;
            cpu_run_q <= 1'b0;
            if (load_len > DEPTH) begin
              state_q   <= ST_ERROR;
              error_q   <= 1'b1;
              s_ready_q <= 1'b0;
              busy_q    <= 1'b0;
            end else begin
              // An empty image goes straight to the checksum byte.
              state_q   <= (load_len == IDX_ZERO) ? ST_CHECK : ST_LOAD;
              error_q   <= 1'b0;
              s_ready_q <= 1'b1;
              busy_q    <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (hs_s) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= wr_addr_d;
            mem_wdata_q <= bus.s_data;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            if (idx_d == len_q) begin
              state_q <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (hs_s) begin
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            if (bus.s_data == sum_q) begin
              state_q   <= ST_DONE;
              done_q    <= 1'b1;
              cpu_run_q <= 1'b1;
            end else begin
              state_q <= ST_ERROR;
              error_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          s_ready_q <= 1'b0;
          busy_q    <= 1'b0;
          cpu_run_q <= 1'b0;
          done_q    <= 1'b0;
          error_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_run       = cpu_run_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed vector table, hand-written corner sequences and
// random images checked against a memory-image and checksum reference model.
module tb_program_loader;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] base_addr;
  logic [8:0] load_len;
  logic       cpu_run, busy, done, error;

  program_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  program_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .load_len(load_len), .bus(bus), .cpu_run(cpu_run), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  base;
    int          len;
    logic [31:0] bytes;
    logic [7:0]  csum;
    bit          gap;
    bit          exp_done;
    bit          exp_err;
    int          exp_wr;
  } vec_t;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         wr_count = 0;
  logic [7:0] dut_mem [256];
  logic [7:0] exp_mem [256];
  logic [7:0] stream  [258];
  logic [7:0] cur_base;
  int         cur_len;
  vec_t       vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Memory model attached to the write port; cpu_run must stay low across every write.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_count <= wr_count + 1;
      dut_mem[bus.mem_addr] <= bus.mem_wdata;
      chk("cpu_run during write", {31'd0, cpu_run}, 32'd0);
    end
  end

  task automatic chk_mem(input string name);
    int bad = -1;
    int idx;
    for (int a = 0; a < 256; a++)
      if (bad < 0 && dut_mem[a] !== exp_mem[a]) bad = a;
    idx = (bad < 0) ? 0 : bad;
    chk($sformatf("%s mem[%02h]", name, idx), {24'd0, dut_mem[idx]}, {24'd0, exp_mem[idx]});
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " s_ready"},   {31'd0, bus.s_ready}, 32'd0);
    chk({name, " mem_we"},    {31'd0, bus.mem_we}, 32'd0);
    chk({name, " mem_addr"},  {24'd0, bus.mem_addr}, 32'd0);
    chk({name, " mem_wdata"}, {24'd0, bus.mem_wdata}, 32'd0);
    chk({name, " cpu_run"},   {31'd0, cpu_run}, 32'd0);
    chk({name, " busy"},      {31'd0, busy}, 32'd0);
    chk({name, " done"},      {31'd0, done}, 32'd0);
    chk({name, " error"},     {31'd0, error}, 32'd0);
  endtask

  // Offers stream[first..total-1]; each payload handshake must show up as a write next cycle.
  task automatic feed(input int first, input int total, input bit gap);
    int k = first;
    int cyc = 0;
    int pk = 0;
    bit pend = 1'b0;
    bit at_neg = 1'b1;
    bit v, rdy;
    int limit = 4 * (total - first) + 20;
    while ((k < total || pend) && cyc < limit) begin
      @(negedge clk);
      at_neg = 1'b1;
      if (pend) begin
        chk("write strobe", {31'd0, bus.mem_we}, 32'd1);
        chk("write addr", {24'd0, bus.mem_addr}, {24'd0, 8'(cur_base + pk)});
        chk("write data", {24'd0, bus.mem_wdata}, {24'd0, stream[pk]});
        pend = 1'b0;
      end
      if (k < total) begin
        v = gap ? (cyc % 2 == 0) : 1'b1;
        bus.s_valid = v;
        bus.s_data  = stream[k];
        rdy = bus.s_ready;
        @(posedge clk);
        at_neg = 1'b0;
        if (v && rdy) begin
          if (k < cur_len) begin
            pend = 1'b1;
            pk   = k;
          end
          k++;
        end
      end
      cyc++;
    end
    if (!at_neg) @(negedge clk);
    bus.s_valid = 1'b0;
    if (k < total || pend) chk("stream timeout", k, total);
  endtask

  task automatic run_load(input string name, input logic [7:0] b, input int len, input bit gap,
                          input bit exp_done, input bit exp_err, input int exp_wr);
    int w0;
    cur_base = b;
    cur_len  = len;
    @(negedge clk);
    w0 = wr_count;
    start = 1'b1; base_addr = b; load_len = 9'(len);
    @(negedge clk);
    start = 1'b0;
    if (len > 256) begin
      chk({name, " illegal error"}, {31'd0, error}, 32'd1);
    end else begin
      chk({name, " s_ready after start"}, {31'd0, bus.s_ready}, 32'd1);
      chk({name, " busy after start"}, {31'd0, busy}, 32'd1);
      chk({name, " done after start"}, {31'd0, done}, 32'd0);
      chk({name, " cpu_run after start"}, {31'd0, cpu_run}, 32'd0);
      chk({name, " error after start"}, {31'd0, error}, 32'd0);
      feed(0, len + 1, gap);
      for (int i = 0; i < len; i++) exp_mem[8'(b + i)] = stream[i];
    end
    chk({name, " done"}, {31'd0, done}, {31'd0, exp_done});
    chk({name, " error"}, {31'd0, error}, {31'd0, exp_err});
    chk({name, " cpu_run"}, {31'd0, cpu_run}, {31'd0, exp_done});
    chk({name, " s_ready idle"}, {31'd0, bus.s_ready}, 32'd0);
    chk({name, " busy idle"}, {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    chk({name, " write count"}, wr_count - w0, exp_wr);
    chk_mem(name);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int len, s, w0;
    bit good;
    logic [7:0] b;
    logic [31:0] bytes;

    for (int a = 0; a < 256; a++) begin
      dut_mem[a] = 8'h00;
      exp_mem[a] = 8'h00;
    end
    vecs[0] = '{8'h10, 3,   32'h01020300, 8'h06, 1'b0, 1'b1, 1'b0, 3};
    vecs[1] = '{8'hFE, 4,   32'hAABBCCDD, 8'h0E, 1'b1, 1'b1, 1'b0, 4};
    vecs[2] = '{8'h00, 2,   32'h80800000, 8'h01, 1'b0, 1'b0, 1'b1, 2};
    vecs[3] = '{8'h00, 2,   32'h80800000, 8'h00, 1'b0, 1'b1, 1'b0, 2};
    vecs[4] = '{8'h33, 0,   32'h00000000, 8'h00, 1'b0, 1'b1, 1'b0, 0};
    vecs[5] = '{8'h50, 1,   32'h7F000000, 8'h7F, 1'b1, 1'b1, 1'b0, 1};
    vecs[6] = '{8'h40, 257, 32'h00000000, 8'h00, 1'b0, 1'b0, 1'b1, 0};
    vecs[7] = '{8'h70, 0,   32'h00000000, 8'h01, 1'b0, 1'b0, 1'b1, 0};

    reset_n = 1'b0; start = 1'b0; base_addr = 8'h00; load_len = 9'd0;
    bus.s_valid = 1'b0; bus.s_data = 8'h00;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      bytes = vecs[v].bytes;
      for (int i = 0; i < 4; i++) stream[i] = bytes[31 - 8*i -: 8];
      if (vecs[v].len <= 256) stream[vecs[v].len] = vecs[v].csum;
      run_load($sformatf("vec%0d", v), vecs[v].base, vecs[v].len, vecs[v].gap,
               vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_wr);
    end

    // Reload from DONE, then start pulsed mid-load must be ignored.
    stream[0] = 8'h11; stream[1] = 8'h22; stream[2] = 8'h33;
    run_load("pre-ignore", 8'hA0, 0, 1'b0, 1'b0, 1'b1, 0);
    cur_base = 8'h60; cur_len = 2;
    stream[0] = 8'h11; stream[1] = 8'h22; stream[2] = 8'h33;
    @(negedge clk); w0 = wr_count;
    start = 1'b1; base_addr = 8'h60; load_len = 9'd2;
    @(negedge clk); start = 1'b0;
    feed(0, 1, 1'b0);
    start = 1'b1; base_addr = 8'hC0; load_len = 9'd5;
    @(negedge clk); start = 1'b0;
    chk("start in LOAD busy", {31'd0, busy}, 32'd1);
    chk("start in LOAD s_ready", {31'd0, bus.s_ready}, 32'd1);
    feed(1, 3, 1'b0);
    chk("start in LOAD done", {31'd0, done}, 32'd1);
    exp_mem[8'h60] = 8'h11; exp_mem[8'h61] = 8'h22;
    repeat (2) @(negedge clk);
    chk("start in LOAD writes", wr_count - w0, 32'd2);
    chk_mem("start in LOAD");

    // Stream bytes offered in DONE are not consumed.
    w0 = wr_count;
    for (int i = 0; i < 3; i++) begin
      bus.s_valid = 1'b1; bus.s_data = 8'(i + 5);
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("DONE ignores stream done", {31'd0, done}, 32'd1);
    chk("DONE ignores stream writes", wr_count - w0, 32'd0);

    // Reset in the middle of a load.
    cur_base = 8'h20; cur_len = 8;
    for (int i = 0; i < 9; i++) stream[i] = 8'($urandom_range(0, 255));
    @(negedge clk);
    start = 1'b1; base_addr = 8'h20; load_len = 9'd8;
    @(negedge clk); start = 1'b0;
    feed(0, 3, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    chk_all_zero("mid-load reset");
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) exp_mem[8'h20 + i] = stream[i];
    repeat (2) @(negedge clk);
    chk_mem("after reset");
    stream[0] = 8'hF0; stream[1] = 8'h20; stream[2] = 8'h10;
    run_load("restart after reset", 8'h90, 2, 1'b0, 1'b1, 1'b0, 2);

    // Random images against the checksum/memory-image model.
    for (int r = 0; r < 25; r++) begin
      case ($urandom_range(0, 9))
        0: len = 0;
        1: len = 256;
        2: len = 257 + $urandom_range(0, 40);
        3: len = 255;
        default: len = $urandom_range(1, 24);
      endcase
      b = 8'($urandom_range(0, 255));
      s = 0;
      if (len <= 256) begin
        for (int i = 0; i < len; i++) begin
          stream[i] = 8'($urandom_range(0, 255));
          s = (s + stream[i]) % 256;
        end
      end
      good = ($urandom_range(0, 3) != 0);
      if (len <= 256) stream[len] = good ? 8'(s) : 8'((s + $urandom_range(1, 255)) % 256);
      run_load($sformatf("rand%0d", r), b, len, 1'($urandom_range(0, 1)),
               (len <= 256) && good, !((len <= 256) && good), (len <= 256) ? len : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/program_loader.md
# program_loader

Synchronous program-image loader that writes a byte stream into the processor's 256×8 memory before execution starts. It keeps the core halted while it loads, then releases it once the image checksum verifies. It is the write-side counterpart of the execution logger, which only reads memory and register state. It sits between the testbench or host byte source and the memory write port, and drives the core's run enable.

## Interface
- ADDR_WIDTH, 8, memory address width; memory depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 8, memory word and stream byte width.
- clk  input  1  system clock; every register updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  load request, sampled only in IDLE, DONE and ERROR.
- base_addr  input  ADDR_WIDTH  first memory address written; latched on start.
- load_len  input  ADDR_WIDTH+1  payload byte count, 0..256; latched on start.
- s_valid  input  1  stream byte valid.
- s_data  input  DATA_WIDTH  stream byte.
- s_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  memory write strobe, one cycle per byte.
- mem_addr  output  ADDR_WIDTH  write address.
- mem_wdata  output  DATA_WIDTH  write data.
- cpu_run  output  1  high = core may execute; low = core held.
- busy  output  1  high while in LOAD or CHECK.
- done  output  1  image loaded and checksum matched.
- error  output  1  checksum mismatch or illegal length.

## Operation
- The FSM has five states: IDLE, LOAD, CHECK, DONE, ERROR.
- Reset: state goes to IDLE. s_ready, mem_we, mem_addr, mem_wdata, cpu_run, busy, done and error all reset to 0. The index and sum registers reset to 0.
- A reset mid-load does not clear memory; bytes already written stay written.
- A handshake is s_valid & s_ready in the same cycle.
- IDLE, DONE or ERROR with start=1:
  - latch base_addr and load_len; clear index and sum;
  - clear done and error; drop cpu_run;
  - if load_len > 256, go to ERROR;
  - if load_len == 0, go to CHECK;
  - otherwise go to LOAD.
- LOAD:
  - s_ready=1.
  - Each handshake writes s_data to base_addr + index. The address is truncated to ADDR_WIDTH, so it wraps at 256 (base 0xFE, len 4 writes FE, FF, 00, 01).
  - Each handshake also updates sum = (sum + s_data) mod 256 and index += 1.
  - When the handshake that makes index equal load_len occurs, go to CHECK.
- CHECK:
  - s_ready=1; the next handshaked byte is the checksum.
  - Byte == sum: go to DONE. Byte != sum: go to ERROR.
  - An empty image (len 0) expects checksum 0x00.
- DONE: done=1 and cpu_run=1. s_ready=0, and further stream bytes are ignored.
- ERROR: error=1, cpu_run=0, s_ready=0. The loader stays in ERROR until a new start.
- start asserted in LOAD or CHECK is ignored; there is no abort other than reset_n.
- s_valid while s_ready=0 is not consumed and does not change state.

## Timing
- start sampled at edge T: state is LOAD and s_ready=1 from T+1.
- Throughput is one byte per cycle with s_valid held high.
- mem_we, mem_addr and mem_wdata are registered. A handshake at edge T produces mem_we=1 with the matching address and data during cycle T+1. mem_we is 0 in every other cycle.
- The last payload handshake at edge T puts the loader in CHECK at T+1, and its write occurs during T+1.
- The checksum handshake at edge T produces done=1 and cpu_run=1 from T+1. cpu_run therefore never rises before the final mem_we has completed.
- A mismatch at edge T produces error=1 from T+1.
- An illegal load_len makes error=1 in the cycle after start, with no writes.
- busy is a registered decode of the state, aligned with s_ready in LOAD and CHECK.
- A new start from DONE drops done and cpu_run the next cycle.

## Test plan
- Basic load: reset, then base 0x10, len 3, bytes 0x01 0x02 0x03, checksum 0x06.
  - Required: writes at 0x10=01, 0x11=02, 0x12=03.
  - Required: done=1 and cpu_run=1 one cycle after the checksum handshake.
- Wrap with backpressure: base 0xFE, len 4, bytes AA BB CC DD, checksum 0x0E, s_valid toggled every other cycle.
  - Required: writes at FE, FF, 00, 01 in order, then done=1.
- Bad checksum: base 0x00, len 2, bytes 0x80 0x80, checksum 0x01.
  - Required: error=1, cpu_run=0, s_ready=0.
  - Required: a following start with correct data reaches done=1.
- Zero and illegal length:
  - len 0 with checksum 0x00: done=1 with no mem_we pulses.
  - len 257: error=1 one cycle after start, with no mem_we pulses.
- Reset mid-load: base 0x20, len 8, reset_n low after 3 bytes.
  - Required: every output is 0 the next cycle.
  - Required: 0x20..0x22 keep the written data; start is accepted again afterwards.
- Reload from DONE: start while done=1.
  - Required: done and cpu_run fall the next cycle.
  - Required: the new image is written and done returns after its checksum.
